// File: rtl/gpu_cmd_queue.sv
// Command FIFO in front of the gpu draw/clear engine: buffers register-bus
// commands and issues each one as stable fields plus a one-cycle strobe.
module gpu_cmd_queue #(
    parameter int DEPTH     = 8,
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    localparam int XW = $clog2(FB_WIDTH) + 2,
    localparam int YW = $clog2(FB_HEIGHT) + 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_type,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [XW-1:0] cmd_width,
    input  logic [YW-1:0] cmd_height,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    input  logic          cmd_flush,
    input  logic          gpu_busy,
    output logic [31:0]   ctrl_address,
    output logic [15:0]   ctrl_address_x,
    output logic [15:0]   ctrl_address_y,
    output logic [15:0]   ctrl_image_width,
    output logic [XW-1:0] ctrl_width,
    output logic [YW-1:0] ctrl_height,
    output logic [XW-1:0] ctrl_x,
    output logic [YW-1:0] ctrl_y,
    output logic [15:0]   ctrl_clear_color,
    output logic          ctrl_draw,
    output logic          ctrl_clear,
    output logic [CW-1:0] queue_count,
    output logic          queue_busy
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [XW-1:0] width;
        logic [YW-1:0] height;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   clear_color;
    } fields_t;

    typedef struct packed {
        logic    is_clear;
        fields_t f;
    } entry_t;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q;
    fields_t         ctrl_q;
    logic            draw_q, clear_q;
    logic            full, push, pop;

    assign full      = (count_q == CW'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !cmd_flush;
    // Flush blocks the launch edge, so a pop never coincides with a flush.
    assign pop       = (state_q == IDLE) && (count_q != '0) && !gpu_busy && !cmd_flush;

    assign wr_entry = '{is_clear: cmd_type,
                        f: '{address: cmd_address, address_x: cmd_address_x,
                             address_y: cmd_address_y, image_width: cmd_image_width,
                             width: cmd_width, height: cmd_height, x: cmd_x, y: cmd_y,
                             clear_color: cmd_clear_color}};
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    always_comb begin
        count_d = count_q;
        if (cmd_flush)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (cmd_flush)
                rd_ptr_q <= wr_ptr_q;
            else if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Fields move only on the launch edge so they hold for the whole gpu operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            draw_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= STROBE;
                        if (head.is_clear) begin
                            ctrl_q.clear_color <= head.f.clear_color;
                            clear_q            <= 1'b1;
                        end else begin
                            ctrl_q.address     <= head.f.address;
                            ctrl_q.address_x   <= head.f.address_x;
                            ctrl_q.address_y   <= head.f.address_y;
                            ctrl_q.image_width <= head.f.image_width;
                            ctrl_q.width       <= head.f.width;
                            ctrl_q.height      <= head.f.height;
                            ctrl_q.x           <= head.f.x;
                            ctrl_q.y           <= head.f.y;
                            draw_q             <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    state_q <= WAIT;
                    draw_q  <= 1'b0;
                    clear_q <= 1'b0;
                end
                WAIT: begin
                    if (!gpu_busy)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctrl_address     = ctrl_q.address;
    assign ctrl_address_x   = ctrl_q.address_x;
    assign ctrl_address_y   = ctrl_q.address_y;
    assign ctrl_image_width = ctrl_q.image_width;
    assign ctrl_width       = ctrl_q.width;
    assign ctrl_height      = ctrl_q.height;
    assign ctrl_x           = ctrl_q.x;
    assign ctrl_y           = ctrl_q.y;
    assign ctrl_clear_color = ctrl_q.clear_color;
    assign ctrl_draw        = draw_q;
    assign ctrl_clear       = clear_q;
    assign queue_count      = count_q;
    assign queue_busy       = (count_q != '0) || (state_q != IDLE) || gpu_busy;
endmodule
